// File: rtl/clint_multi.sv
// clint_multi: multi-hart core-local interruptor with shared prescaled 64-bit mtime, per-hart mtimecmp/msip.
// Optional CLINT_MTIME_HI_LATCH_EN: mtime-lo reads capture mtime[63:32] into a shadow returned by mtime-hi reads.
module clint_multi #(
  parameter int          NUM_HARTS = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          TICK_DIV  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic [3:0]           wstrb,
  input  logic                 read_en,
  output logic [31:0]          rdata,
  output logic                 addr_valid,
  output logic [NUM_HARTS-1:0] timer_irq,
  output logic [NUM_HARTS-1:0] soft_irq
);
  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val, input logic [31:0] new_val,
                                             input logic [3:0] be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    return res;
  endfunction

  logic [63:0]          mtime_reg;
  logic [PW-1:0]        presc_reg;
  logic [63:0]          cmp_val [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip_val;
  logic [NUM_HARTS-1:0] msip_hit;
  logic [NUM_HARTS-1:0] cmp_hit;
  logic                 in_region;
  logic [13:0]          word;
  logic                 upper;
  logic                 mtime_hit;
  logic                 write;
  logic                 tick;
  logic [31:0]          mtime_hi_view;
  logic [31:0]          rd_mux;
  logic                 unused_addr_bits;

  // Word offset within the 64 KiB region; the byte lane bits never affect decode.
  assign in_region        = (addr[31:16] == BASE_ADDR[31:16]);
  assign word             = addr[15:2];
  assign upper            = word[0];
  assign unused_addr_bits = ^addr[1:0];
  assign mtime_hit        = in_region && (word[13:1] == 13'h17FF);
  assign write            = |wstrb;
  assign tick             = (presc_reg == PRESC_MAX);
  assign addr_valid       = (|msip_hit) || (|cmp_hit) || mtime_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime_reg <= '0;
      presc_reg <= '0;
    end else begin
      presc_reg <= tick ? '0 : presc_reg + PW'(1);
      // A software write takes precedence over the tick and suppresses that cycle's increment.
      if (write && mtime_hit) begin
        if (upper) mtime_reg[63:32] <= byte_merge(mtime_reg[63:32], wdata, wstrb);
        else       mtime_reg[31:0]  <= byte_merge(mtime_reg[31:0], wdata, wstrb);
      end else if (tick) begin
        mtime_reg <= mtime_reg + 64'd1;
      end
    end
  end

`ifdef CLINT_MTIME_HI_LATCH_EN
  logic [31:0] shadow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_reg <= '0;
    end else if (write && mtime_hit && upper) begin
      shadow_reg <= byte_merge(mtime_reg[63:32], wdata, wstrb);
    end else if (read_en && mtime_hit && !upper) begin
      shadow_reg <= mtime_reg[63:32];
    end
  end

  assign mtime_hi_view = shadow_reg;
`else
  assign mtime_hi_view = mtime_reg[63:32];
`endif

  for (genvar gi = 0; gi < NUM_HARTS; gi++) begin : g_hart
    logic [63:0] cmp_reg;
    logic        msip_reg;
    logic        timer_irq_reg;
    logic        soft_irq_reg;

    assign msip_hit[gi]  = in_region && (word == 14'(gi));
    assign cmp_hit[gi]   = in_region && (word[13:1] == 13'(2048 + gi));
    assign cmp_val[gi]   = cmp_reg;
    assign msip_val[gi]  = msip_reg;
    assign timer_irq[gi] = timer_irq_reg;
    assign soft_irq[gi]  = soft_irq_reg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cmp_reg       <= '1;
        msip_reg      <= 1'b0;
        timer_irq_reg <= 1'b0;
        soft_irq_reg  <= 1'b0;
      end else begin
        if (write && cmp_hit[gi]) begin
          if (upper) cmp_reg[63:32] <= byte_merge(cmp_reg[63:32], wdata, wstrb);
          else       cmp_reg[31:0]  <= byte_merge(cmp_reg[31:0], wdata, wstrb);
        end
        if (write && msip_hit[gi] && wstrb[0])
          msip_reg <= wdata[0];
        timer_irq_reg <= (mtime_reg >= cmp_reg);
        soft_irq_reg  <= msip_reg;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      if (msip_hit[h]) rd_mux = {31'b0, msip_val[h]};
      if (cmp_hit[h])  rd_mux = upper ? cmp_val[h][63:32] : cmp_val[h][31:0];
    end
    if (mtime_hit) rd_mux = upper ? mtime_hi_view : mtime_reg[31:0];
    rdata = (read_en && addr_valid) ? rd_mux : 32'h0;
  end
endmodule

// File: tb/tb_clint_multi.sv
// tb_clint_multi: two clint_multi instances (TICK_DIV 4 and 1) driven by one bus, each
// compared against a register-map level model; directed scenarios followed by random traffic.
module tb_clint_multi;
  localparam int          NH   = 2;
  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam logic [31:0] IDLE = BASE + 32'h8000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr, wdata;
  logic [3:0]    wstrb;
  logic          read_en;
  logic [31:0]   rdata_a, rdata_b;
  logic          av_a, av_b;
  logic [NH-1:0] tirq_a, tirq_b, sirq_a, sirq_b;

  clint_multi #(.NUM_HARTS(NH), .BASE_ADDR(BASE), .TICK_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wstrb(wstrb), .read_en(read_en),
    .rdata(rdata_a), .addr_valid(av_a), .timer_irq(tirq_a), .soft_irq(sirq_a));

  clint_multi #(.NUM_HARTS(NH), .BASE_ADDR(BASE), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .wstrb(wstrb), .read_en(read_en),
    .rdata(rdata_b), .addr_valid(av_b), .timer_irq(tirq_b), .soft_irq(sirq_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Model state, slot 0 = dut_a, slot 1 = dut_b.
  int            div [2] = '{4, 1};
  logic [63:0]   m_time [2];
  logic [63:0]   m_cmp [2][NH];
  logic          m_msip [2][NH];
  logic [31:0]   m_shadow [2];
  logic [NH-1:0] m_tirq [2];
  logic [NH-1:0] m_sirq [2];
  int            edges;
  logic [31:0]   last_a, last_b;

  task automatic model_reset();
    edges = 0;
    for (int s = 0; s < 2; s++) begin
      m_time[s] = '0; m_shadow[s] = '0; m_tirq[s] = '0; m_sirq[s] = '0;
      for (int h = 0; h < NH; h++) begin
        m_cmp[s][h] = 64'hFFFF_FFFF_FFFF_FFFF;
        m_msip[s][h] = 1'b0;
      end
    end
  endtask

  // kind: 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
  function automatic void decode(input logic [31:0] a, output int kind, output int h, output int hi);
    logic [31:0] off;
    kind = 0; h = 0; hi = 0;
    off = a - BASE;
    if (a < BASE || off >= 32'h1_0000) return;
    off = off & ~32'h3;
    if (off < 32'(4 * NH)) begin
      kind = 1; h = int'(off / 4);
    end else if (off >= 32'h4000 && off < 32'h4000 + 32'(8 * NH)) begin
      kind = 2; h = int'((off - 32'h4000) / 8); hi = int'((off % 8) / 4);
    end else if (off == 32'hBFF8 || off == 32'hBFFC) begin
      kind = 3; hi = (off == 32'hBFFC) ? 1 : 0;
    end
  endfunction

  function automatic logic [31:0] merged(input logic [31:0] old_val, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] r;
    r = old_val;
    for (int b = 0; b < 4; b++)
      if (ws[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input int s, input logic [31:0] a);
    int kind, h, hi;
    decode(a, kind, h, hi);
    case (kind)
      1: return {31'b0, m_msip[s][h]};
      2: return (hi != 0) ? m_cmp[s][h][63:32] : m_cmp[s][h][31:0];
      3: begin
        if (hi == 0) return m_time[s][31:0];
`ifdef CLINT_MTIME_HI_LATCH_EN
        return m_shadow[s];
`else
        return m_time[s][63:32];
`endif
      end
      default: return 32'h0;
    endcase
  endfunction

  // One bus cycle: combinational outputs are checked at the negedge, irqs just after the posedge.
  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws, input logic re);
    int kind, h, hi;
    logic [31:0] nv;
    addr = a; wdata = wd; wstrb = ws; read_en = re;
    @(negedge clk);
    decode(a, kind, h, hi);
    check("addr_valid_a", av_a, kind != 0);
    check("addr_valid_b", av_b, kind != 0);
    check("rdata_a", rdata_a, re ? m_read(0, a) : 32'h0);
    check("rdata_b", rdata_b, re ? m_read(1, a) : 32'h0);
    last_a = rdata_a;
    last_b = rdata_b;
    edges++;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < NH; k++) begin
        m_tirq[s][k] = (m_time[s] >= m_cmp[s][k]);
        m_sirq[s][k] = m_msip[s][k];
      end
      if (re && kind == 3 && hi == 0) m_shadow[s] = m_time[s][63:32];
      if (ws != 0 && kind == 3) begin
        if (hi != 0) begin
          nv = merged(m_time[s][63:32], wd, ws);
          m_time[s][63:32] = nv;
          m_shadow[s] = nv;
        end else begin
          m_time[s][31:0] = merged(m_time[s][31:0], wd, ws);
        end
      end else if (edges % div[s] == 0) begin
        m_time[s] = m_time[s] + 64'd1;
      end
      if (ws != 0 && kind == 2) begin
        if (hi != 0) m_cmp[s][h][63:32] = merged(m_cmp[s][h][63:32], wd, ws);
        else         m_cmp[s][h][31:0]  = merged(m_cmp[s][h][31:0], wd, ws);
      end
      if (ws[0] && kind == 1) m_msip[s][h] = wd[0];
    end
    @(posedge clk);
    #1;
    check("timer_irq_a", tirq_a, m_tirq[0]);
    check("timer_irq_b", tirq_b, m_tirq[1]);
    check("soft_irq_a", sirq_a, m_sirq[0]);
    check("soft_irq_b", sirq_b, m_sirq[1]);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    step(a, d, 4'hF, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    step(a, 32'h0, 4'h0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(IDLE, 32'h0, 4'h0, 1'b0);
  endtask

  logic [31:0] pick [10];

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; wstrb = '0; read_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_tirq_a", tirq_a, '0);
    check("reset_sirq_b", sirq_b, '0);
    rst = 1'b0;

    rd(BASE + 32'hBFF8);
    rd(BASE + 32'h4004);

    // Byte-strobed write into mtimecmp[0] lo, then an out-of-range hart slot.
    step(BASE + 32'h4000, 32'h0000_00AB, 4'b0001, 1'b0);
    rd(BASE + 32'h4000);
    check("cmp0_byte_write", last_a, 32'hFFFF_FFAB);
    wr(BASE + 32'h4010, 32'hDEAD_BEEF);
    rd(BASE + 32'h4010);
    check("unmapped_read", last_b, 32'h0);

    // Prescaled count: two ticks of TICK_DIV=4 in eight cycles.
    wr(BASE + 32'hBFFC, 32'h0);
    wr(BASE + 32'hBFF8, 32'h100);
    idle(8);
    rd(BASE + 32'hBFF8);
    check("div4_mtime_lo", last_a, 32'h102);
    check("div4_no_timer", tirq_a, '0);

    // Carry from lo into hi.
    wr(BASE + 32'hBFFC, 32'h0);
    wr(BASE + 32'hBFF8, 32'hFFFF_FFFF);
    idle(2);
    rd(BASE + 32'hBFFC);
    check("carry_hi", last_b, 32'h1);
    rd(BASE + 32'hBFF8);

    // Timer compare on hart 1 only.
    wr(BASE + 32'hBFFC, 32'h0);
    wr(BASE + 32'hBFF8, 32'h100);
    wr(BASE + 32'h4008, 32'h10);
    wr(BASE + 32'h400C, 32'h0);
    idle(1);
    check("timer_h1_a", tirq_a, 2'b10);
    check("timer_h1_b", tirq_b, 2'b10);
    wr(BASE + 32'h400C, 32'hFFFF_FFFF);
    idle(1);
    check("timer_clear_b", tirq_b, 2'b00);

    // Software interrupt on hart 1; only bit 0 is stored.
    wr(BASE + 32'h4, 32'h1);
    idle(1);
    check("soft_h1", sirq_a, 2'b10);
    wr(BASE + 32'h4, 32'hFFFF_FFFE);
    idle(1);
    check("soft_clear", sirq_b, 2'b00);
    rd(BASE + 32'h4);
    check("msip_read", last_a, 32'h0);

    // Tear-free mtime read sequence.
    wr(BASE + 32'hBFFC, 32'h0);
    wr(BASE + 32'hBFF8, 32'hFFFF_FFF0);
    rd(BASE + 32'hBFF8);
    idle(32);
    rd(BASE + 32'hBFFC);
`ifdef CLINT_MTIME_HI_LATCH_EN
    check("hi_latched", last_b, 32'h0);
`else
    check("hi_live", last_b, 32'h1);
`endif

    // Asynchronous reset between clock edges.
    wr(BASE + 32'h0, 32'h1);
    wr(BASE + 32'h4000, 32'h0);
    wr(BASE + 32'h4004, 32'h0);
    idle(1);
    check("pre_reset_soft", sirq_b, 2'b01);
    addr = BASE + 32'hBFF8; read_en = 1'b1; wstrb = '0;
    rst = 1'b1;
    #2;
    check("async_rst_tirq", tirq_b, '0);
    check("async_rst_sirq", sirq_a, '0);
    check("async_rst_mtime", rdata_b, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Random traffic around the implemented registers.
    pick = '{BASE, BASE + 32'h4, BASE + 32'h8, BASE + 32'h4000, BASE + 32'h4004,
             BASE + 32'h4008, BASE + 32'h400C, BASE + 32'h4010, BASE + 32'hBFF8, BASE + 32'hBFFC};
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, d;
      logic [3:0]  ws;
      a  = ($urandom_range(0, 9) == 0) ? $urandom : (pick[$urandom_range(0, 9)] | 32'($urandom_range(0, 3)));
      d  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 300));
      ws = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(a, d, ws, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
